sudoku_loader: RTL
==================

Name: sudoku_loader

Overview:
- Sequential writer that builds the 729-bit one-hot puzzle vector consumed by the team's candidate-mask logic.
- Accepts one decimal cell digit per handshake, in row-major order, 81 cells per load.
- Converts each digit to a 9-bit one-hot field and assembles the full puzzle register.
- Sits between the puzzle input interface and the mask/partials logic inside the sudoku_check wrapper.

Parameters:
- CLEAR_ON_START, 1: 1 = puzzle_reg_bin cleared to 0 on accepted start; 0 = prior contents retained and overwritten cell by cell.
- CELLS, 81: cells per load; only 81 is supported; cell_idx width is 7.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a new load; level is sampled each cycle
- in_valid  input  1  in_digit is valid
- in_digit  input  4  0 = empty cell, 1..9 = given digit, 10..15 = illegal
- in_ready  output  1  loader accepts a digit this cycle
- puzzle_reg_bin  output  729  one-hot puzzle; bit index = (row*9+col)*9 + (digit-1)
- cell_idx  output  7  index of the next cell to be written, 0..80
- busy  output  1  high in LOAD state
- load_done  output  1  one-cycle pulse after cell 80 is accepted
- load_err  output  1  sticky: an illegal digit was seen during the current load

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; puzzle_reg_bin=0; cell_idx=0.
  - in_ready, busy, load_done, load_err all 0.
- States: IDLE, LOAD, DONE. All outputs are registered; in_ready = (state==LOAD).
- IDLE:
  - start=1 -> next cycle LOAD; cell_idx=0; load_err=0; puzzle_reg_bin=0 if CLEAR_ON_START.
  - in_valid is ignored.
- LOAD:
  - Transfer occurs when in_valid & in_ready.
  - On transfer, field [cell_idx*9+8 : cell_idx*9] is written the next cycle:
    - digit d in 1..9 -> only bit (d-1) set;
    - digit 0 -> all nine bits 0;
    - digit 10..15 -> all nine bits 0 and load_err set to 1.
  - cell_idx increments by 1 on each transfer. No wrap: a transfer at cell_idx=80 moves to DONE and leaves cell_idx at 80.
  - No transfer -> no change; stalls of any length are allowed.
  - start=1 while in LOAD restarts the load: same actions as the IDLE start. Start has priority over a simultaneous transfer, which is discarded.
- DONE:
  - Lasts exactly one cycle with load_done=1 and in_ready=0, then returns to IDLE.
  - start during DONE is ignored.
- puzzle_reg_bin holds its value in IDLE and DONE and only changes on transfers or start-clears.
- Latency: a digit accepted in cycle N appears in puzzle_reg_bin in cycle N+1. load_done is high in the cycle after the final transfer.
- load_err remains set until the next accepted start or reset.
- Reset asserted mid-load aborts immediately to the reset values. No partial state survives.
- No field ever has more than one bit set.

Test Plan:
- Reset, then start, then 81 transfers of digits (idx mod 9)+1 with in_valid held high:
  - busy high for 81 cycles; load_done pulses once, one cycle after the last transfer;
  - field k equals 1<<(k mod 9); load_err=0.
- Load with cell 0 = 5, cell 80 = 9, all others 0:
  - puzzle_reg_bin has only bits 4 and 728 set.
- in_valid toggled 1,0,0,1 repeatedly over a full load:
  - exactly 81 transfers; cell_idx tracks only accepted digits; result matches the unstalled run.
- Digit 12 at cell 3, all other cells 7:
  - field 3 = 0; load_err=1 through DONE and IDLE; cleared by the next start.
- start reasserted after 40 cells (CLEAR_ON_START=1):
  - puzzle_reg_bin=0 and cell_idx=0 next cycle; the transfer in the start cycle is discarded.
- rst_n dropped asynchronously mid-cycle at cell 50:
  - all outputs at reset values immediately; a subsequent full load completes normally.

Source files
------------

// File: rtl/sudoku_loader.sv
// Sequential loader: accepts one decimal digit per handshake in row-major order
// and assembles the 81-cell, 9-bit-per-cell one-hot puzzle vector.
module sudoku_loader #(
  parameter bit CLEAR_ON_START = 1'b1,
  parameter int CELLS          = 81
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  input  logic [3:0]   in_digit,
  output logic         in_ready,
  output logic [728:0] puzzle_reg_bin,
  output logic [6:0]   cell_idx,
  output logic         busy,
  output logic         load_done,
  output logic         load_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [6:0] LAST_IDX = 7'(CELLS - 1);

  logic [1:0] r_state;
  logic [8:0] w_onehot;
  logic       w_illegal;
  logic       w_transfer;
  logic [9:0] w_base;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_onehot = '0;
    if (in_digit >= 4'd1 && in_digit <= 4'd9) begin
      w_onehot = 9'b1 << (in_digit - 4'd1);
    end
  end

  assign w_illegal  = (in_digit > 4'd9);
  assign w_transfer = in_valid && (r_state == LOAD);
  assign w_base     = 10'(cell_idx) * 10'd9;

  // Status outputs are pure decodes of the state register.
  assign in_ready  = (r_state == LOAD);
  assign busy      = (r_state == LOAD);
  assign load_done = (r_state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the wide puzzle register is reset too, so an aborted load leaves no stale cells behind.
      r_state        <= IDLE;
      puzzle_reg_bin <= '0;
      cell_idx       <= '0;
      load_err       <= 1'b0;
    end else if (start && r_state != DONE) begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      r_state  <= LOAD;
      cell_idx <= '0;
      load_err <= 1'b0;
      if (CLEAR_ON_START) begin
        puzzle_reg_bin <= '0;
      end
    end else begin
      case (r_state)
        IDLE: ;
        LOAD: begin
          if (w_transfer) begin
            puzzle_reg_bin[w_base +: 9] <= w_onehot;
            if (w_illegal) begin
              load_err <= 1'b1;
            end
            // The final cell parks the index at 80 rather than wrapping.
            if (cell_idx == LAST_IDX) begin
              r_state <= DONE;
            end else begin
              cell_idx <= cell_idx + 7'd1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
